// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the status LED bank controller.
// Holds the LED width, arbiter state encoding and index helper.
package led_ctrl_pkg;

  localparam int LED_W   = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  function automatic logic [2:0] onehot_to_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational first-set picker scanning upward from a start index.
// Fixed mode always scans from index 0.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  input  logic          rr_mode,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [PW-1:0] base;
  logic [PW-1:0] idx;

  always_comb begin
    base  = rr_mode ? start : '0;
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(base) + i) % N);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Grants the 8-bit status LED bank to one requester at a time,
// with minimum dwell, maximum tenure preemption and LED masking.
module led_bank_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_CYCLES  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [LED_W*N_REQ-1:0] i_pattern,
  input  logic                   i_rr_mode,
  input  logic [LED_W-1:0]       i_led_mask,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_busy,
  output logic [LED_W-1:0]       o_led
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic             excl_q, excl_d;
  logic [PW-1:0]    excl_idx_q, excl_idx_d;
  logic [LED_W-1:0] led_q, led_d;

  logic [MAX_REQ-1:0] grant_ext;
  logic [PW-1:0]      owner;
  logic [N_REQ-1:0]   excl_oh;
  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   pick;
  logic               pick_valid;
  logic [LED_W-1:0]   pat_sel;
  logic               owner_req;
  logic               others_req;
  logic               hold_done;
  logic               at_max;
  logic               rel;
  logic               preempt;

  always_comb begin
    grant_ext = '0;
    grant_ext[N_REQ-1:0] = grant_q;
  end

  assign owner = PW'(onehot_to_idx(grant_ext));

  always_comb begin
    excl_oh = '0;
    if (excl_q) excl_oh[excl_idx_q] = 1'b1;
  end

  assign elig = i_req & ~excl_oh;

  rr_priority_picker #(
    .N  (N_REQ),
    .PW (PW)
  ) u_picker (
    .req     (elig),
    .start   (rr_q),
    .rr_mode (i_rr_mode),
    .pick    (pick),
    .valid   (pick_valid)
  );

  always_comb begin
    pat_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) pat_sel = i_pattern[k*LED_W +: LED_W];
    end
  end

  assign owner_req  = |(i_req & grant_q);
  assign others_req = |(i_req & ~grant_q);
  assign hold_done  = cnt_q >= CW'(HOLD_CYCLES - 1);
  assign at_max     = cnt_q >= CW'(MAX_CYCLES - 1);
  assign rel        = !owner_req && hold_done;
  // A drop coinciding with the tenure limit counts as a plain release
  assign preempt    = at_max && others_req && !rel;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    excl_d     = excl_q;
    excl_idx_d = excl_idx_q;
    unique case (state_q)
      IDLE: begin
        // Exclusion only ever applies to one arbitration cycle
        excl_d = 1'b0;
        if (pick_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (cnt_q != CW'(MAX_CYCLES)) cnt_d = cnt_q + CW'(1);
        if (rel || preempt) begin
          state_d = IDLE;
          grant_d = '0;
          if (owner == PW'(N_REQ - 1)) rr_d = '0;
          else rr_d = owner + PW'(1);
          if (preempt) begin
            excl_d     = 1'b1;
            excl_idx_d = owner;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign led_d = (state_q == OWNED) ? (pat_sel & i_led_mask) : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      excl_q     <= 1'b0;
      excl_idx_q <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      excl_q     <= excl_d;
      excl_idx_q <= excl_idx_d;
      led_q      <= led_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q == OWNED);
  assign o_led   = led_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter: vector table plus
// hand-written preemption, exclusion, saturation and reset sequences.
module tb_led_bank_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [31:0] i_pattern;
  logic        i_rr_mode;
  logic [7:0]  i_led_mask;
  logic [3:0]  o_grant;
  logic        o_busy;
  logic [7:0]  o_led;

  int n_chk;
  int n_fail;

  led_bank_arbiter #(
    .N_REQ       (4),
    .HOLD_CYCLES (4),
    .MAX_CYCLES  (16)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_pattern  (i_pattern),
    .i_rr_mode  (i_rr_mode),
    .i_led_mask (i_led_mask),
    .o_grant    (o_grant),
    .o_busy     (o_busy),
    .o_led      (o_led)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pat;
    logic        mode;
    logic [7:0]  mask;
    logic [3:0]  g;
    logic        b;
    logic [7:0]  led;
  } vec_t;

  localparam int NV = 20;
  vec_t tv[NV];

  localparam logic [31:0] P1 = 32'h44A52211;
  localparam logic [31:0] P2 = 32'h443C2211;
  localparam logic [31:0] P3 = 32'h4455F366;
  localparam logic [31:0] PQ = 32'h8421C3A5;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tenure(input string nm, input logic [3:0] g,
                        input int n, input logic [7:0] led);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s_grant_c%0d", nm, i), 32'(o_grant), 32'(g));
      check($sformatf("%s_busy_c%0d", nm, i), 32'(o_busy), 32'd1);
      check($sformatf("%s_led_c%0d", nm, i), 32'(o_led),
            (i == 0) ? 32'd0 : 32'(led));
    end
  endtask

  task automatic gap(input string nm, input logic [7:0] led);
    step();
    check({nm, "_grant"}, 32'(o_grant), 32'd0);
    check({nm, "_busy"}, 32'(o_busy), 32'd0);
    check({nm, "_led"}, 32'(o_led), 32'(led));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    tv[0]  = '{4'b0100, P1, 1'b0, 8'hFF, 4'b0100, 1'b1, 8'h00};
    tv[1]  = '{4'b0100, P1, 1'b0, 8'hFF, 4'b0100, 1'b1, 8'hA5};
    tv[2]  = '{4'b0100, P1, 1'b0, 8'hFF, 4'b0100, 1'b1, 8'hA5};
    tv[3]  = '{4'b0100, P2, 1'b0, 8'hFF, 4'b0100, 1'b1, 8'h3C};
    tv[4]  = '{4'b0100, P2, 1'b0, 8'hFF, 4'b0100, 1'b1, 8'h3C};
    tv[5]  = '{4'b0100, P2, 1'b0, 8'hFF, 4'b0100, 1'b1, 8'h3C};
    tv[6]  = '{4'b0000, P2, 1'b0, 8'hFF, 4'b0000, 1'b0, 8'h3C};
    tv[7]  = '{4'b0000, P2, 1'b0, 8'hFF, 4'b0000, 1'b0, 8'h00};
    tv[8]  = '{4'b0010, P3, 1'b0, 8'hFF, 4'b0010, 1'b1, 8'h00};
    tv[9]  = '{4'b0010, P3, 1'b0, 8'hFF, 4'b0010, 1'b1, 8'hF3};
    tv[10] = '{4'b0000, P3, 1'b0, 8'h0F, 4'b0010, 1'b1, 8'h03};
    tv[11] = '{4'b0000, P3, 1'b0, 8'h0F, 4'b0010, 1'b1, 8'h03};
    tv[12] = '{4'b0000, P3, 1'b0, 8'h0F, 4'b0000, 1'b0, 8'h03};
    tv[13] = '{4'b0000, P3, 1'b0, 8'h0F, 4'b0000, 1'b0, 8'h00};
    tv[14] = '{4'b1001, P3, 1'b1, 8'hFF, 4'b1000, 1'b1, 8'h00};
    tv[15] = '{4'b1001, P3, 1'b1, 8'hFF, 4'b1000, 1'b1, 8'h44};
    tv[16] = '{4'b0000, P3, 1'b1, 8'hFF, 4'b1000, 1'b1, 8'h44};
    tv[17] = '{4'b0000, P3, 1'b1, 8'hFF, 4'b1000, 1'b1, 8'h44};
    tv[18] = '{4'b0000, P3, 1'b1, 8'hFF, 4'b0000, 1'b0, 8'h44};
    tv[19] = '{4'b0000, P3, 1'b1, 8'hFF, 4'b0000, 1'b0, 8'h00};

    i_reset    = 1'b0;
    i_req      = 4'($urandom);
    i_pattern  = $urandom;
    i_rr_mode  = 1'($urandom);
    i_led_mask = 8'($urandom);
    #1 i_reset = 1'b1;
    #2;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_led", 32'(o_led), 32'd0);
    step();
    step();
    check("rst_hold_grant", 32'(o_grant), 32'd0);
    check("rst_hold_led", 32'(o_led), 32'd0);
    i_req   = 4'b0000;
    i_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("post_rst_grant%0d", i), 32'(o_grant), 32'd0);
      check($sformatf("post_rst_busy%0d", i), 32'(o_busy), 32'd0);
      check($sformatf("post_rst_led%0d", i), 32'(o_led), 32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      i_req      = tv[i].req;
      i_pattern  = tv[i].pat;
      i_rr_mode  = tv[i].mode;
      i_led_mask = tv[i].mask;
      step();
      check($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(tv[i].g));
      check($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(tv[i].b));
      check($sformatf("vec%0d_led", i), 32'(o_led), 32'(tv[i].led));
    end

    i_rr_mode  = 1'b0;
    i_req      = 4'b1100;
    i_pattern  = PQ;
    i_led_mask = 8'hF0;
    tenure("fx2a", 4'b0100, 16, 8'h20);
    gap("fx2a_gap", 8'h20);
    tenure("fx3a", 4'b1000, 16, 8'h80);
    gap("fx3a_gap", 8'h80);
    tenure("fx2b", 4'b0100, 16, 8'h20);
    gap("fx2b_gap", 8'h20);
    tenure("fx3b", 4'b1000, 8, 8'h80);

    #2 i_reset = 1'b1;
    #1;
    check("mid_rst_grant", 32'(o_grant), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_led", 32'(o_led), 32'd0);
    #2 i_reset = 1'b0;
    i_rr_mode  = 1'b1;
    i_req      = 4'b1011;
    i_led_mask = 8'hFF;

    tenure("rr0", 4'b0001, 16, 8'hA5);
    gap("rr0_gap", 8'hA5);
    tenure("rr1", 4'b0010, 16, 8'hC3);
    gap("rr1_gap", 8'hC3);
    tenure("rr3", 4'b1000, 16, 8'h84);
    gap("rr3_gap", 8'h84);

    i_req = 4'b0001;
    tenure("sat0", 4'b0001, 24, 8'hA5);
    i_req = 4'b0011;
    gap("sat_pre", 8'hA5);
    tenure("rr1b", 4'b0010, 16, 8'hC3);
    gap("rr1b_gap", 8'hC3);
    tenure("rr0b", 4'b0001, 16, 8'hA5);

    i_req = 4'b0010;
    gap("drop_pre", 8'hA5);
    i_req     = 4'b0011;
    i_rr_mode = 1'b0;
    step();
    check("no_excl_grant", 32'(o_grant), 32'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
